jpeg_rgb_store: RTL and testbench

Downstream sink for the `jpeg_decode` pixel output port. It converts the decoder's MCU-ordered pixel stream into raster-addressed 32-bit memory write requests under a valid/ready handshake. A small FIFO absorbs backpressure, because the decoder output cannot be stalled. The block also counts stored pixels and reports end of frame and overflow.

---
 rtl/jpeg_rgb_store.sv | 193 +++++++++++++++++++
 tb/tb_jpeg_rgb_store.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jpeg_rgb_store.sv
// jpeg_rgb_store: turns the decoder's MCU-ordered pixel stream into
// raster-addressed 32-bit write requests, with a small FIFO and frame tracking.
module jpeg_rgb_store #(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter int                FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        FrameStart,
    input  logic                        PixEnable,
    input  logic [15:0]                 PixWidth,
    input  logic [15:0]                 PixHeight,
    input  logic [15:0]                 PixX,
    input  logic [15:0]                 PixY,
    input  logic [7:0]                  PixR,
    input  logic [7:0]                  PixG,
    input  logic [7:0]                  PixB,
    output logic                        WrValid,
    input  logic                        WrReady,
    output logic [ADDR_W-1:0]           WrAddr,
    output logic [31:0]                 WrData,
    output logic [$clog2(FIFO_DEPTH):0] Level,
    output logic                        Overflow,
    output logic                        Dropped,
    output logic                        FrameDone,
    output logic [31:0]                 PixelCount
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    typedef enum logic {IDLE, RUN} state_t;

    // stage 1
    logic        s1_en_q;
    logic [15:0] s1_x_q, s1_y_q, s1_w_q, s1_h_q;
    logic [7:0]  s1_r_q, s1_g_q, s1_b_q;

    // stage 2
    logic              s2_ok_q, s2_bad_q;
    logic [ADDR_W-1:0] s2_addr_q;
    logic [31:0]       s2_data_q, s2_tgt_q;

    logic [31:0]       idx, off;
    logic [ADDR_W-1:0] addr_w;
    logic              in_range;

    // fifo
    logic [ADDR_W-1:0] addr_mem [FIFO_DEPTH];
    logic [31:0]       data_mem [FIFO_DEPTH];
    logic [AW:0]       wp_q, rp_q, count;
    logic              full, empty, push, pop, ovf;

    // status and frame tracking
    logic        ovf_q, drop_q, done_q, done_d, final_pop;
    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d, tgt_q, tgt_d;

    assign idx      = 32'(s1_w_q) * 32'(s1_y_q) + 32'(s1_x_q);
    assign off      = {idx[29:0], 2'b00};
    assign addr_w   = BASE_ADDR + ADDR_W'(off);
    assign in_range = (s1_x_q < s1_w_q) && (s1_y_q < s1_h_q);

    // Input register: capture the decoder port every cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_en_q <= 1'b0;
            s1_x_q  <= '0;
            s1_y_q  <= '0;
            s1_w_q  <= '0;
            s1_h_q  <= '0;
            s1_r_q  <= '0;
            s1_g_q  <= '0;
            s1_b_q  <= '0;
        end else begin
            s1_en_q <= PixEnable;
            s1_x_q  <= PixX;
            s1_y_q  <= PixY;
            s1_w_q  <= PixWidth;
            s1_h_q  <= PixHeight;
            s1_r_q  <= PixR;
            s1_g_q  <= PixG;
            s1_b_q  <= PixB;
        end
    end

    // Address stage: raster address, range test and frame size
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_ok_q   <= 1'b0;
            s2_bad_q  <= 1'b0;
            s2_addr_q <= '0;
            s2_data_q <= '0;
            s2_tgt_q  <= '0;
        end else begin
            s2_ok_q   <= s1_en_q & in_range;
            s2_bad_q  <= s1_en_q & ~in_range;
            s2_addr_q <= addr_w;
            s2_data_q <= {8'h00, s1_r_q, s1_g_q, s1_b_q};
            s2_tgt_q  <= 32'(s1_w_q) * 32'(s1_h_q);
        end
    end

    assign count = wp_q - rp_q;
    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);
    assign pop   = ~empty & WrReady;
    // a full FIFO still accepts a push when the head leaves in the same cycle
    assign push  = s2_ok_q & (~full | pop);
    assign ovf   = s2_ok_q & full & ~pop;

    // FIFO storage; no reset needed, outputs are gated by occupancy
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wp_q[AW-1:0]] <= s2_addr_q;
            data_mem[wp_q[AW-1:0]] <= s2_data_q;
        end
    end

    // FIFO pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            if (push) wp_q <= wp_q + 1'b1;
            if (pop)  rp_q <= rp_q + 1'b1;
        end
    end

    assign WrValid = ~empty;
    assign WrAddr  = empty ? '0 : addr_mem[rp_q[AW-1:0]];
    assign WrData  = empty ? '0 : data_mem[rp_q[AW-1:0]];
    assign Level   = count;

    // Sticky status flags; a new discard wins over FrameStart
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q  <= 1'b0;
            drop_q <= 1'b0;
        end else begin
            if (ovf)             ovf_q <= 1'b1;
            else if (FrameStart) ovf_q <= 1'b0;
            if (s2_bad_q)        drop_q <= 1'b1;
        end
    end

    // Frame tracking next state: count pops, detect the final one, re-arm
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tgt_d     = tgt_q;
        done_d    = 1'b0;
        final_pop = pop && (state_q == RUN) && !FrameStart
                    && (cnt_q + 32'd1 == tgt_q);
        if (FrameStart) begin
            cnt_d   = '0;
            state_d = IDLE;
        end else if (final_pop) begin
            cnt_d   = '0;
            state_d = IDLE;
            done_d  = 1'b1;
        end else if (pop) begin
            cnt_d   = cnt_q + 32'd1;
        end
        if (push && state_d == IDLE) begin
            state_d = RUN;
            tgt_d   = s2_tgt_q;
        end
    end

    // Frame tracking state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tgt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
            done_q  <= done_d;
        end
    end

    assign Overflow   = ovf_q;
    assign Dropped    = drop_q;
    assign FrameDone  = done_q;
    assign PixelCount = cnt_q;

endmodule

// File: tb/tb_jpeg_rgb_store.sv
// tb_jpeg_rgb_store: directed vectors for jpeg_rgb_store
// (raster, MCU order, backpressure, range, reset, FrameStart).
module tb_jpeg_rgb_store;

    logic        clk = 1'b0;
    logic        rst;
    logic        FrameStart, PixEnable, WrReady;
    logic [15:0] PixWidth, PixHeight, PixX, PixY;
    logic [7:0]  PixR, PixG, PixB;
    logic        WrValid, Overflow, Dropped, FrameDone;
    logic [31:0] WrAddr, WrData, PixelCount;
    logic [4:0]  Level;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int hs_cyc = 0;
    int done_cyc = 0;
    int done_cnt = 0;
    logic [31:0] got_addr[$];
    logic [31:0] got_data[$];

    typedef struct {
        logic [15:0] x, y;
        logic [7:0]  r, g, b;
        logic [31:0] addr, data;
    } vec_t;

    vec_t t1[8];
    logic [31:0] ea[128];
    logic [31:0] ed[128];

    jpeg_rgb_store #(
        .ADDR_W(32), .BASE_ADDR(32'h1000), .FIFO_DEPTH(16)
    ) dut (
        .clk(clk), .rst(rst), .FrameStart(FrameStart),
        .PixEnable(PixEnable), .PixWidth(PixWidth), .PixHeight(PixHeight),
        .PixX(PixX), .PixY(PixY), .PixR(PixR), .PixG(PixG), .PixB(PixB),
        .WrValid(WrValid), .WrReady(WrReady), .WrAddr(WrAddr), .WrData(WrData),
        .Level(Level), .Overflow(Overflow), .Dropped(Dropped),
        .FrameDone(FrameDone), .PixelCount(PixelCount)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // write/FrameDone monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst && WrValid && WrReady) begin
            got_addr.push_back(WrAddr);
            got_data.push_back(WrData);
            hs_cyc <= cyc;
        end
        if (FrameDone) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
    end

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic ticks(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pix(int x, int y, int r, int g, int b);
        PixEnable = 1'b1;
        PixX = 16'(x);
        PixY = 16'(y);
        PixR = 8'(r);
        PixG = 8'(g);
        PixB = 8'(b);
        @(posedge clk);
        #1;
        PixEnable = 1'b0;
    endtask

    task automatic wait_writes(int n, int budget);
        for (int i = 0; i < budget && got_addr.size() < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frame_start();
        FrameStart = 1'b1;
        ticks(1);
        FrameStart = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, d0;
        int k;

        t1[0] = '{16'd0, 16'd0, 8'd0, 8'd0, 8'h55, 32'h1000, 32'h0000_0055};
        t1[1] = '{16'd1, 16'd0, 8'd1, 8'd0, 8'h55, 32'h1004, 32'h0001_0055};
        t1[2] = '{16'd2, 16'd0, 8'd2, 8'd0, 8'h55, 32'h1008, 32'h0002_0055};
        t1[3] = '{16'd3, 16'd0, 8'd3, 8'd0, 8'h55, 32'h100C, 32'h0003_0055};
        t1[4] = '{16'd0, 16'd1, 8'd0, 8'd1, 8'h55, 32'h1010, 32'h0000_0155};
        t1[5] = '{16'd1, 16'd1, 8'd1, 8'd1, 8'h55, 32'h1014, 32'h0001_0155};
        t1[6] = '{16'd2, 16'd1, 8'd2, 8'd1, 8'h55, 32'h1018, 32'h0002_0155};
        t1[7] = '{16'd3, 16'd1, 8'd3, 8'd1, 8'h55, 32'h101C, 32'h0003_0155};

        rst = 1'b1;
        FrameStart = 1'b0;
        PixEnable = 1'b0;
        WrReady = 1'b0;
        PixWidth = '0;
        PixHeight = '0;
        PixX = '0;
        PixY = '0;
        PixR = '0;
        PixG = '0;
        PixB = '0;
        ticks(2);
        rst = 1'b0;

        chk("rst_wrvalid", 32'(WrValid), 32'd0);
        chk("rst_wraddr", WrAddr, 32'd0);
        chk("rst_wrdata", WrData, 32'd0);
        chk("rst_level", 32'(Level), 32'd0);
        chk("rst_overflow", 32'(Overflow), 32'd0);
        chk("rst_dropped", 32'(Dropped), 32'd0);
        chk("rst_framedone", 32'(FrameDone), 32'd0);
        chk("rst_pixelcount", PixelCount, 32'd0);

        // raster 4x2 from the vector table
        PixWidth = 16'd4;
        PixHeight = 16'd2;
        WrReady = 1'b1;
        n0 = got_addr.size();
        d0 = done_cnt;
        for (int i = 0; i < 8; i++) begin
            pix(int'(t1[i].x), int'(t1[i].y), int'(t1[i].r),
                int'(t1[i].g), int'(t1[i].b));
            if (i < 2) chk("t1_latency_low", 32'(WrValid), 32'd0);
            if (i == 2) chk("t1_latency_high", 32'(WrValid), 32'd1);
        end
        wait_writes(n0 + 8, 20);
        ticks(2);
        chk("t1_nwrites", 32'(got_addr.size() - n0), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (n0 + i < got_addr.size()) begin
                chk("t1_addr", got_addr[n0+i], t1[i].addr);
                chk("t1_data", got_data[n0+i], t1[i].data);
            end
        end
        chk("t1_done_count", 32'(done_cnt - d0), 32'd1);
        chk("t1_done_timing", 32'(done_cyc - hs_cyc), 32'd1);
        chk("t1_pixelcount", PixelCount, 32'd0);

        // 16x8 image fed in 8x8 block order
        PixWidth = 16'd16;
        PixHeight = 16'd8;
        n0 = got_addr.size();
        d0 = done_cnt;
        k = 0;
        for (int bx = 0; bx < 2; bx++) begin
            for (int yy = 0; yy < 8; yy++) begin
                for (int xx = 0; xx < 8; xx++) begin
                    ea[k] = 32'h1000 + 32'((16 * yy + bx * 8 + xx) * 4);
                    ed[k] = {8'h00, 8'(bx * 8 + xx), 8'(yy), 8'h55};
                    pix(bx * 8 + xx, yy, bx * 8 + xx, yy, 8'h55);
                    k++;
                end
            end
        end
        wait_writes(n0 + 128, 200);
        ticks(3);
        chk("t2_nwrites", 32'(got_addr.size() - n0), 32'd128);
        for (int i = 0; i < 128; i++) begin
            if (n0 + i < got_addr.size()) begin
                chk("t2_addr", got_addr[n0+i], ea[i]);
                chk("t2_data", got_data[n0+i], ed[i]);
            end
        end
        if (n0 + 89 < got_addr.size()) begin
            chk("t2_pix_9_3_addr", got_addr[n0+89], 32'h10E4);
            chk("t2_pix_9_3_data", got_data[n0+89], 32'h0009_0355);
        end
        chk("t2_done_count", 32'(done_cnt - d0), 32'd1);
        chk("t2_pixelcount", PixelCount, 32'd0);

        // backpressure: fill, hold, overflow, drain
        WrReady = 1'b0;
        frame_start();
        n0 = got_addr.size();
        for (int i = 0; i < 16; i++) pix(i, 0, i, 0, 8'h55);
        ticks(3);
        chk("t3_level_full", 32'(Level), 32'd16);
        chk("t3_wrvalid", 32'(WrValid), 32'd1);
        chk("t3_head_addr", WrAddr, 32'h1000);
        chk("t3_head_data", WrData, 32'h0000_0055);
        chk("t3_no_overflow_yet", 32'(Overflow), 32'd0);
        ticks(4);
        chk("t3_addr_stable", WrAddr, 32'h1000);
        chk("t3_data_stable", WrData, 32'h0000_0055);
        pix(0, 1, 0, 1, 8'h55);
        ticks(3);
        chk("t3_overflow", 32'(Overflow), 32'd1);
        chk("t3_level_after_ovf", 32'(Level), 32'd16);
        WrReady = 1'b1;
        wait_writes(n0 + 16, 40);
        ticks(3);
        chk("t3_drain_count", 32'(got_addr.size() - n0), 32'd16);
        if (n0 + 15 < got_addr.size())
            chk("t3_last_addr", got_addr[n0+15], 32'h103C);
        chk("t3_level_empty", 32'(Level), 32'd0);
        chk("t3_pixelcount", PixelCount, 32'd16);

        // full FIFO with simultaneous push and pop
        WrReady = 1'b0;
        frame_start();
        chk("t4_overflow_cleared", 32'(Overflow), 32'd0);
        n0 = got_addr.size();
        for (int i = 0; i < 16; i++) pix(i, 1, i, 1, 8'h55);
        ticks(3);
        chk("t4_level_full", 32'(Level), 32'd16);
        for (int i = 0; i < 10; i++) begin
            pix(i, 2, i, 2, 8'h55);
            if (i == 1) WrReady = 1'b1;
            if (i >= 2) chk("t4_level_held", 32'(Level), 32'd16);
        end
        ticks(2);
        chk("t4_level_tail", 32'(Level), 32'd16);
        chk("t4_no_overflow", 32'(Overflow), 32'd0);
        wait_writes(n0 + 26, 60);
        ticks(2);
        chk("t4_nwrites", 32'(got_addr.size() - n0), 32'd26);

        // out-of-range pixels and zero width
        frame_start();
        PixWidth = 16'd4;
        PixHeight = 16'd2;
        chk("t5_dropped_before", 32'(Dropped), 32'd0);
        n0 = got_addr.size();
        d0 = done_cnt;
        pix(4, 0, 1, 2, 3);
        ticks(4);
        chk("t5_no_write", 32'(got_addr.size() - n0), 32'd0);
        chk("t5_wrvalid", 32'(WrValid), 32'd0);
        chk("t5_dropped", 32'(Dropped), 32'd1);
        chk("t5_pixelcount", PixelCount, 32'd0);
        PixWidth = 16'd0;
        pix(0, 0, 1, 2, 3);
        ticks(4);
        chk("t5_w0_no_write", 32'(got_addr.size() - n0), 32'd0);
        PixWidth = 16'd4;
        PixHeight = 16'd1;
        for (int i = 0; i < 4; i++) pix(i, 0, i, 0, 8'h55);
        ticks(6);
        chk("t5_w4h1_writes", 32'(got_addr.size() - n0), 32'd4);
        chk("t5_w4h1_done", 32'(done_cnt - d0), 32'd1);
        chk("t5_w4h1_count", PixelCount, 32'd0);

        // reset mid-stream with pixels queued and in flight
        WrReady = 1'b0;
        PixWidth = 16'd16;
        PixHeight = 16'd8;
        for (int i = 0; i < 5; i++) pix(i, 0, i, 0, 8'h55);
        ticks(3);
        chk("t6_level5", 32'(Level), 32'd5);
        pix(5, 0, 5, 0, 8'h55);
        pix(6, 0, 6, 0, 8'h55);
        rst = 1'b1;
        ticks(1);
        chk("t6_rst_level", 32'(Level), 32'd0);
        chk("t6_rst_wrvalid", 32'(WrValid), 32'd0);
        chk("t6_rst_overflow", 32'(Overflow), 32'd0);
        chk("t6_rst_dropped", 32'(Dropped), 32'd0);
        chk("t6_rst_framedone", 32'(FrameDone), 32'd0);
        chk("t6_rst_pixelcount", PixelCount, 32'd0);
        rst = 1'b0;
        ticks(4);
        chk("t6_inflight_gone", 32'(Level), 32'd0);

        // FrameStart in the same cycle as a pop
        for (int i = 0; i < 17; i++) pix(i % 16, 3, i, 3, 8'h55);
        ticks(3);
        chk("t6_fill_level", 32'(Level), 32'd16);
        chk("t6_fill_overflow", 32'(Overflow), 32'd1);
        WrReady = 1'b1;
        ticks(2);
        chk("t6_count_two", PixelCount, 32'd2);
        FrameStart = 1'b1;
        ticks(1);
        FrameStart = 1'b0;
        WrReady = 1'b0;
        chk("t6_fs_pop_count", PixelCount, 32'd0);
        chk("t6_fs_overflow", 32'(Overflow), 32'd0);
        chk("t6_fs_level", 32'(Level), 32'd13);
        WrReady = 1'b1;
        ticks(16);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
